sm3_core_arbiter: RTL
=====================

// Module: sm3_core_arbiter
// PURPOSE
//  Shares one two-block SM3 hash core (1024-bit padded message -> 256-bit digest) among NUM_REQ requesters.
//  Examples of requesters: SM2 sign/verify, KDF and ZA computation.
//  - Round-robin arbitration; buffers the winning message and launches the core.
//  - Watches the core with a watchdog and returns the digest, or an error, to the granted requester.
//  - Also owns the core's active-low reset.
// PARAMETERS
//  NUM_REQ  4    number of requesters (2..8)
//  ID_W     2    grant id width, = clog2(NUM_REQ)
//  TIMEOUT  200  max cycles in BUSY before abort (core needs 131)
// PORTS
//  clk          in   1             single clock, all logic posedge
//  rst          in   1             synchronous reset, active-high
//  req          in   NUM_REQ       per-requester request level
//  req_data     in   NUM_REQ*1024  requester i message at [i*1024 +: 1024], padded, big-endian word 0 at MSB
//  req_ack      out  NUM_REQ       1-cycle pulse: message captured, requester may drop req/data
//  resp_valid   out  NUM_REQ       1-cycle pulse to owning requester
//  resp_hash    out  256           digest, valid with resp_valid (shared bus)
//  resp_err     out  1             qualifies resp_valid: 1 = watchdog abort, resp_hash = 0
//  busy         out  1             high in every state except IDLE
//  core_rstn    out  1             core async active-low reset, registered
//  core_start   out  1             core start
//  core_datain  out  1024          core message input
//  core_hashout in   256           core digest
//  core_valid   in   1             core done pulse
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - State IDLE; all outputs 0, except core_rstn = 0 while rst is high and 1 from the cycle after rst falls.
//   - rr pointer = 0; data buffer, owner id and watchdog cleared.
//   - Reset mid-job discards the job with no response. The core is reset through core_rstn.
//  FSM: IDLE -> LAUNCH -> BUSY -> RESP -> IDLE; BUSY -> ABORT -> RESP
//   - IDLE: if |req, pick the first set bit at or after ptr (cyclic).
//     - Latch owner = winner and buf = req_data[winner]; go LAUNCH.
//     - If no requests, stay.
//   - LAUNCH (1 cycle):
//     - core_start = 1, core_datain = buf, req_ack[owner] = 1.
//     - ptr <= owner+1, wrapping NUM_REQ-1 -> 0.
//     - Go BUSY; wdog <= 0.
//   - BUSY: core_datain stays = buf; wdog++ each cycle.
//     - core_valid = 1: latch hash <= core_hashout, err <= 0, go RESP.
//     - Otherwise, wdog == TIMEOUT-1: go ABORT.
//   - ABORT (2 cycles): core_rstn = 0; hash <= 0, err <= 1; then go RESP.
//   - RESP (1 cycle): resp_valid[owner] = 1, resp_hash = hash, resp_err = err; go IDLE.
//  Latency and throughput
//   - Requests sampled in IDLE cycle t: LAUNCH at t+1, core_valid at t+132, resp_valid at t+133.
//   - Next arbitration happens at t+134, so there are 134 cycles per job.
//  Output timing: all outputs come from registers, except core_start/core_datain/req_ack, which decode state only.
//  Boundaries
//   - Simultaneous requests: strict round-robin; with all req high, grants go 0,1,2,3,0...
//   - Requests arriving in a non-IDLE state: ignored until IDLE, no loss (req is a level).
//   - The owner may drop req after req_ack; its data is held in buf.
//   - A req dropped before ack is simply never granted.
//   - core_valid outside BUSY is ignored.
//   - core_valid in the same cycle as the watchdog expiring: valid wins.
//   - resp_hash/resp_err hold their last values when resp_valid = 0.
// STRUCTURE
//  Shared package sm3_pkg holds:
//   - SM3_BLK_W = 1024, SM3_HASH_W = 256, SM3_CORE_LAT = 131
//   - state encoding (one-hot, 5 states)
//  One sub-module, sm3_rr_arbiter:
//   - inputs req and ptr; outputs grant_id and grant_any; purely combinational.
//   - Rotate, priority-encode, un-rotate.
//  Top-level flops: FSM, buf[1023:0], owner, ptr, wdog[7:0], hash, err, core_rstn.
// TESTING (bench instantiates the real SM3 core)
//  1. Single request from req[1]:
//     - Message "abcd"x16 padded: 64 bytes of 61626364, then 80000000, zeros, final word 00000200.
//     - Required: req_ack[1] at t+1; resp_valid[1] at t+133; resp_err = 0.
//     - resp_hash = debe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732.
//  2. All four req high together with distinct messages:
//     - Acks in order 0,1,2,3, each 134 cycles apart.
//     - Each resp_valid lands on its owner with the matching model digest.
//  3. req[2] pulsed low after req_ack while busy, with req_data changed to garbage:
//     - Digest still matches the captured message.
//  4. Core stubbed with core_valid tied 0:
//     - core_rstn low for 2 cycles after 200 BUSY cycles.
//     - resp_valid[owner] = 1, resp_err = 1, resp_hash = 0.
//     - The next request completes normally.
//  5. rst asserted at BUSY cycle 50:
//     - No resp_valid; busy = 0 and core_rstn = 0 next cycle.
//     - After release, req[3] completes with the correct digest and ptr is restarted from 0.
//  6. Spurious core_valid injected in IDLE: no resp_valid, state unchanged.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared SM3 widths, core latency and arbiter FSM state encoding.
package sm3_pkg;

  localparam int SM3_BLK_W    = 1024;
  localparam int SM3_HASH_W   = 256;
  localparam int SM3_CORE_LAT = 131;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_LAUNCH = 5'b00010,
    ST_BUSY   = 5'b00100,
    ST_ABORT  = 5'b01000,
    ST_RESP   = 5'b10000
  } arb_state_e;

endpackage

// File: rtl/sm3_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, cyclically.
// Rotates req so ptr lands at bit 0, priority-encodes, then rotates the index back.
module sm3_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    rot_id;

  always_comb begin
    rot       = '0;
    rot_id    = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[ID_W'((i + int'(ptr)) % NUM_REQ)];
    end
    // Descending scan so the lowest rotated index is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_id    = ID_W'(i);
        grant_any = 1'b1;
      end
    end
    grant_id = ID_W'((int'(rot_id) + int'(ptr)) % NUM_REQ);
  end

endmodule

// File: rtl/sm3_core_arbiter.sv
// Shares one SM3 core among NUM_REQ requesters: round-robin grant, launch, watchdog, respond.
// 134 cycles per job; requests are levels and simply wait while the block is busy.
module sm3_core_arbiter
  import sm3_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 200
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*SM3_BLK_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [SM3_HASH_W-1:0]         resp_hash,
  output logic                          resp_err,
  output logic                          busy,
  output logic                          core_rstn,
  output logic                          core_start,
  output logic [SM3_BLK_W-1:0]          core_datain,
  input  logic [SM3_HASH_W-1:0]         core_hashout,
  input  logic                          core_valid
);

  localparam logic [7:0] WDOG_LAST      = 8'(TIMEOUT - 1);
  localparam logic [7:0] WDOG_ABORT_END = 8'(TIMEOUT + 1);

  arb_state_e              state_q, state_nxt;
  logic [SM3_BLK_W-1:0]    msg_buf;
  logic [ID_W-1:0]         owner_q;
  logic [ID_W-1:0]         ptr_q;
  logic [7:0]              wdog_q;
  logic [SM3_HASH_W-1:0]   hash_q;
  logic                    err_q;
  logic [ID_W-1:0]         grant_id;
  logic                    grant_any;
  logic [NUM_REQ-1:0]      resp_sel;
  logic [SM3_BLK_W-1:0]    req_msg [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg
    assign req_msg[g] = req_data[g*SM3_BLK_W +: SM3_BLK_W];
  end

  sm3_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    state_nxt   = state_q;
    core_start  = 1'b0;
    core_datain = '0;
    req_ack     = '0;
    resp_sel    = '0;
    case (state_q)
      ST_IDLE:   if (grant_any) state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        state_nxt        = ST_BUSY;
        core_start       = 1'b1;
        core_datain      = msg_buf;
        req_ack[owner_q] = 1'b1;
      end
      ST_BUSY: begin
        core_datain = msg_buf;
        // A done pulse coinciding with watchdog expiry still counts as success.
        if (core_valid)               state_nxt = ST_RESP;
        else if (wdog_q == WDOG_LAST) state_nxt = ST_ABORT;
      end
      ST_ABORT:  if (wdog_q == WDOG_ABORT_END) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (state_nxt == ST_RESP) resp_sel[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      msg_buf    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      wdog_q     <= '0;
      hash_q     <= '0;
      err_q      <= 1'b0;
      core_rstn  <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= '0;
    end else begin
      state_q    <= state_nxt;
      busy       <= (state_nxt != ST_IDLE);
      core_rstn  <= (state_nxt != ST_ABORT);
      resp_valid <= resp_sel;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            owner_q <= grant_id;
            msg_buf <= req_msg[grant_id];
          end
        end
        ST_LAUNCH: begin
          ptr_q  <= (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          wdog_q <= '0;
        end
        ST_BUSY: begin
          wdog_q <= wdog_q + 8'd1;
          if (core_valid) begin
            hash_q <= core_hashout;
            err_q  <= 1'b0;
          end
        end
        // The watchdog keeps counting through ABORT to time the two-cycle core reset.
        ST_ABORT: begin
          wdog_q <= wdog_q + 8'd1;
          hash_q <= '0;
          err_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_hash = hash_q;
  assign resp_err  = err_q;

endmodule
